// File: rtl/systolic_mm_stream.sv
// Output-stationary SIZE x SIZE systolic matrix multiplier: skews A columns and
// B rows into a registered PE grid, then streams C out one row per handshake.

module systolic_mm_pe #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  acc
);
    logic signed [2*DATA_WIDTH-1:0] prod;

    assign prod = a * b;

    // Wraps modulo 2^ACC_WIDTH; the product is sign-extended by the cast.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= acc + ACC_WIDTH'(prod);
    end
endmodule

module systolic_mm_stream #(
    parameter int SIZE       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int K_MAX      = 16,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+$clog2(K_MAX)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [$clog2(K_MAX+1)-1:0]                 k_len,
    output logic                                       busy,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [SIZE*DATA_WIDTH-1:0]                 a_col,
    input  logic [SIZE*DATA_WIDTH-1:0]                 b_row,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [((SIZE > 1) ? $clog2(SIZE) : 1)-1:0] out_row_idx,
    output logic [SIZE*ACC_WIDTH-1:0]                  out_row_data,
    output logic                                       done
);
    localparam int KW  = $clog2(K_MAX+1);
    localparam int RW  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int DCW = $clog2(2*SIZE);
    localparam logic [KW-1:0]  K_CAP      = KW'(K_MAX);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2*SIZE-2);
    localparam logic [RW-1:0]  ROW_LAST   = RW'(SIZE-1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUT} state_t;

    state_t         state;
    logic [KW-1:0]  k_lat;
    logic [KW-1:0]  beat_cnt;
    logic [DCW-1:0] drain_cnt;
    logic           accept;
    logic           clr;

    logic [SIZE-1:0][DATA_WIDTH-1:0]            a_inj, b_inj, a_sk, b_sk;
    logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0]  a_pe, b_pe;
    logic [SIZE-1:0][SIZE-1:0][ACC_WIDTH-1:0]   acc;

    assign accept = in_valid && in_ready;
    assign clr    = (state == S_IDLE) && start && (k_len != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
            out_row_idx <= '0;
            k_lat       <= '0;
            beat_cnt    <= '0;
            drain_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clr) begin
                        k_lat       <= (k_len > K_CAP) ? K_CAP : k_len;
                        beat_cnt    <= '0;
                        drain_cnt   <= '0;
                        out_row_idx <= '0;
                        busy        <= 1'b1;
                        in_ready    <= 1'b1;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + KW'(1);
                        if (beat_cnt == k_lat - KW'(1)) begin
                            in_ready  <= 1'b0;
                            drain_cnt <= '0;
                            state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // 2*SIZE-1 cycles: farthest skew + hops + accumulate register
                    if (drain_cnt == DRAIN_LAST) begin
                        out_valid   <= 1'b1;
                        out_row_idx <= '0;
                        state       <= S_OUT;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (out_row_idx == ROW_LAST) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            out_row_idx <= out_row_idx + RW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_lane
            assign a_inj[gi] = accept ? a_col[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
            assign b_inj[gi] = accept ? b_row[gi*DATA_WIDTH +: DATA_WIDTH] : '0;

            // Lane gi is delayed gi cycles so A[i][k] and B[k][j] meet at PE(i,j).
            if (gi == 0) begin : g_noskew
                assign a_sk[gi] = a_inj[gi];
                assign b_sk[gi] = b_inj[gi];
            end else begin : g_skew
                logic [gi-1:0][DATA_WIDTH-1:0] a_sr, b_sr;

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        a_sr <= '0;
                        b_sr <= '0;
                    end else if (clr) begin
                        a_sr <= '0;
                        b_sr <= '0;
                    end else begin
                        a_sr[0] <= a_inj[gi];
                        b_sr[0] <= b_inj[gi];
                        for (int s = 1; s < gi; s++) begin
                            a_sr[s] <= a_sr[s-1];
                            b_sr[s] <= b_sr[s-1];
                        end
                    end
                end

                assign a_sk[gi] = a_sr[gi-1];
                assign b_sk[gi] = b_sr[gi-1];
            end
        end
    endgenerate

    // a_pe[i][j] / b_pe[i][j] are the operands presented to PE(i,j); a hops right, b down.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_pe <= '0;
            b_pe <= '0;
        end else if (clr) begin
            a_pe <= '0;
            b_pe <= '0;
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                a_pe[i][0] <= a_sk[i];
                b_pe[0][i] <= b_sk[i];
                for (int j = 1; j < SIZE; j++) begin
                    a_pe[i][j] <= a_pe[i][j-1];
                    b_pe[j][i] <= b_pe[j-1][i];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_row
            for (gj = 0; gj < SIZE; gj++) begin : g_col
                systolic_mm_pe #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .ACC_WIDTH  (ACC_WIDTH)
                ) u_pe (
                    .clk (clk),
                    .rst (rst),
                    .clr (clr),
                    .en  (busy),
                    .a   (a_pe[gi][gj]),
                    .b   (b_pe[gi][gj]),
                    .acc (acc[gi][gj])
                );
            end
        end

        for (gj = 0; gj < SIZE; gj++) begin : g_out
            assign out_row_data[gj*ACC_WIDTH +: ACC_WIDTH] = acc[out_row_idx][gj];
        end
    endgenerate
endmodule

// File: tb/tb_systolic_mm_stream.sv
// Directed bench for systolic_mm_stream (SIZE=4, DATA_WIDTH=8, K_MAX=16).
module tb_systolic_mm_stream;
    localparam int S  = 4;
    localparam int DW = 8;
    localparam int KM = 16;
    localparam int AW = 20;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [4:0]     k_len = '0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b1;
    logic [S*DW-1:0] a_col = '0;
    logic [S*DW-1:0] b_row = '0;
    logic           busy, in_ready, out_valid, done;
    logic [1:0]     out_row_idx;
    logic [S*AW-1:0] out_row_data;

    int checks = 0, errors = 0, cyc = 0, c0 = 0, load_cyc = 0, drain_cyc = 0;
    int ma[S][KM];
    int mb[KM][S];
    int mc[S][S];

    systolic_mm_stream #(.SIZE(S), .DATA_WIDTH(DW), .K_MAX(KM), .ACC_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k_len        (k_len),
        .busy         (busy),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_col        (a_col),
        .b_row        (b_row),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row_idx  (out_row_idx),
        .out_row_data (out_row_data),
        .done         (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (in_ready) load_cyc++;
        if (busy && !in_ready && !out_valid) drain_cyc++;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic longint lane(input int j);
        return longint'($signed(out_row_data[j*AW +: AW]));
    endfunction

    function automatic void model(input int k);
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++) begin
                mc[i][j] = 0;
                for (int kk = 0; kk < k; kk++) mc[i][j] += ma[i][kk] * mb[kk][j];
            end
    endfunction

    function automatic void clear_ops();
        for (int i = 0; i < S; i++)
            for (int k = 0; k < KM; k++) begin
                ma[i][k] = 0;
                mb[k][i] = 0;
            end
    endfunction

    task automatic start_job(input logic [4:0] kl);
        c0 = cyc;
        start = 1'b1;
        k_len = kl;
        @(posedge clk); #1;
        start = 1'b0;
        k_len = '0;
    endtask

    // gaps: idle on even cycles; poke: hold start with k_len=2 during LOAD
    task automatic send_beats(input int k, input bit gaps, input bit poke);
        int n = 0;
        int t = 0;
        bit hs;
        while (n < k && t < 100) begin
            if (gaps && (t % 2 == 0)) begin
                in_valid = 1'b0;
                a_col = '0;
                b_row = '0;
            end else begin
                in_valid = 1'b1;
                for (int i = 0; i < S; i++) begin
                    a_col[i*DW +: DW] = 8'(ma[i][n]);
                    b_row[i*DW +: DW] = 8'(mb[n][i]);
                end
            end
            if (poke) begin
                start = 1'b1;
                k_len = 5'd2;
            end
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) n++;
            t++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        k_len = '0;
        chk("beats_accepted", n, k);
    endtask

    // lat>0: first out_valid must be lat cycles after c0; chain_k>0: start on the done cycle
    task automatic collect(input int lat, input int stall_row, input int chain_k);
        int t = 0;
        int r = 0;
        int hs_cnt = 0;
        int st = 0;
        bit hs;
        while (!out_valid && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (lat > 0) chk("latency", cyc - c0, lat);
        while (r < S && t < 400) begin
            hs = 1'b0;
            if (out_valid) begin
                chk($sformatf("row%0d_idx", r), out_row_idx, r);
                for (int j = 0; j < S; j++)
                    chk($sformatf("c%0d%0d", r, j), lane(j), mc[r][j]);
                if (r == stall_row && st < 5) begin
                    out_ready = 1'b0;
                    st++;
                end else begin
                    out_ready = 1'b1;
                end
                hs = out_ready;
            end
            @(posedge clk); #1;
            t++;
            if (hs) begin
                r++;
                hs_cnt++;
            end
        end
        out_ready = 1'b1;
        chk("rows_issued", hs_cnt, S);
        chk("done_set", done, 1);
        chk("busy_end", busy, 0);
        if (chain_k > 0) begin
            c0 = cyc;
            start = 1'b1;
            k_len = 5'(chain_k);
            @(posedge clk); #1;
            start = 1'b0;
            k_len = '0;
            chk("chain_busy", busy, 1);
            chk("chain_in_ready", in_ready, 1);
        end else begin
            @(posedge clk); #1;
        end
        chk("done_pulse", done, 0);
    endtask

    initial begin
        int ta[S][S];
        int tb[S][S];

        #2 rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", out_row_idx, 0);
        chk("rst_data", out_row_data, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // identity x B, start with another k_len held during LOAD
        clear_ops();
        for (int i = 0; i < S; i++) ma[i][i] = 1;
        mb[0] = '{1, 2, 3, 4};
        mb[1] = '{-5, 6, -7, 8};
        mb[2] = '{9, 10, 11, 12};
        mb[3] = '{13, -14, 15, -16};
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++) mc[i][j] = mb[i][j];
        start_job(5'd4);
        chk("a_busy", busy, 1);
        send_beats(4, 1'b0, 1'b1);
        collect(12, -1, 0);

        // signed operands with alternating gaps, row 1 stalled 5 cycles
        ta = '{'{127, -128, 3, -7}, '{12, -45, 100, -1}, '{0, 9, -9, 64}, '{-128, -128, 127, 127}};
        tb = '{'{-128, 5, -6, 77}, '{-2, 127, 33, -90}, '{50, -50, 1, 0}, '{-128, -128, -128, -128}};
        clear_ops();
        for (int i = 0; i < S; i++)
            for (int k = 0; k < S; k++) begin
                ma[i][k] = ta[i][k];
                mb[k][i] = tb[k][i];
            end
        model(4);
        load_cyc = 0;
        drain_cyc = 0;
        start_job(5'd4);
        send_beats(4, 1'b1, 1'b0);
        collect(0, 1, 0);
        chk("b_load_cyc", load_cyc, 8);
        chk("b_drain_cyc", drain_cyc, 7);

        // K clamped from 31 to 16, all operands -128
        for (int i = 0; i < S; i++)
            for (int k = 0; k < KM; k++) begin
                ma[i][k] = -128;
                mb[k][i] = -128;
            end
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++) mc[i][j] = 262144;
        start_job(5'd31);
        send_beats(16, 1'b0, 1'b0);
        chk("c_clamp_load_end", in_ready, 0);
        collect(24, -1, 0);

        // k_len=0 is ignored
        start_job(5'd0);
        chk("k0_busy", busy, 0);
        chk("k0_in_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("k0_busy2", busy, 0);

        // reset during DRAIN
        clear_ops();
        ma[0][0] = 1;  ma[0][1] = 2;
        ma[1][0] = 3;  ma[1][1] = 4;
        ma[2][0] = -1; ma[2][1] = 0;
        ma[3][0] = 0;  ma[3][1] = -2;
        mb[0] = '{1, 0, 2, -1};
        mb[1] = '{0, 1, 1, 3};
        start_job(5'd2);
        send_beats(2, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("e_in_drain", busy && !in_ready && !out_valid, 1);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        for (int j = 0; j < S; j++) chk($sformatf("abort_c0%0d", j), lane(j), 0);
        @(posedge clk); #1;
        chk("abort_busy2", busy, 0);
        chk("abort_data2", out_row_data, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // fresh job after abort; next job starts on the done cycle
        mc = '{'{1, 2, 4, 5}, '{3, 4, 10, 9}, '{-1, 0, -2, 1}, '{0, -2, -2, -6}};
        start_job(5'd2);
        send_beats(2, 1'b0, 1'b0);
        collect(10, -1, 1);

        clear_ops();
        ma[0][0] = 2; ma[1][0] = -3; ma[2][0] = 5; ma[3][0] = 7;
        mb[0] = '{1, -1, 4, -128};
        model(1);
        send_beats(1, 1'b0, 1'b0);
        collect(9, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
